// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared CPU encodings for the multiply/divide unit.
package mul_div_unit_pkg;
  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;
endpackage

// File: rtl/mul_div_unit_mux2.sv
// mul_div_unit_mux2: generic W-bit 2:1 mux.
module mul_div_unit_mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_zero
);
  localparam int CW = $clog2(N);
  mdu_state_e     state, state_n;
  logic [2*N-1:0] acc, neg_prod;
  logic [N-1:0]   rem, opb, abs_a, abs_b;
  logic [N-1:0]   hi_raw, hi_neg, hi_fix, lo_fix;
  logic [CW-1:0]  cnt;
  logic           sign_q, sign_r, div_q, div0_q;
  logic           accept, signed_in, div_in, div0_in, hi_sel, borrow;
  logic [N:0]     mul_sum, div_sh;
  logic [N+1:0]   div_tr;
  always_comb begin
    accept    = (state == IDLE) && start;
    signed_in = (op == MDU_MULT) || (op == MDU_DIV);
    div_in    = (op == MDU_DIVU) || (op == MDU_DIV);
    div0_in   = div_in && (b == '0);
    abs_a     = (signed_in && a[N-1]) ? -a : a;
    abs_b     = (signed_in && b[N-1]) ? -b : b;
    mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, acc[0] ? opb : {N{1'b0}}};
    div_sh    = {rem, acc[N-1]};
    div_tr    = {1'b0, div_sh} - {2'b0, opb};
    borrow    = div_tr[N+1];
    neg_prod  = -acc;
    hi_raw    = div_q ? rem : acc[2*N-1:N];
    hi_neg    = div_q ? -rem : neg_prod[2*N-1:N];
    hi_sel    = div_q ? sign_r : sign_q;
    state_n   = state == IDLE ? (start ? (div0_in ? FIX : CALC) : IDLE) :
                state == CALC ? (cnt == '0 ? FIX : CALC) :
                state == FIX  ? DONE : IDLE;
  end
  // the low half of the negated product equals the negated quotient, so one source serves both
  mul_div_unit_mux2 #(.W(N)) u_hi_mux (.sel(hi_sel), .d0(hi_raw), .d1(hi_neg), .y(hi_fix));
  mul_div_unit_mux2 #(.W(N)) u_lo_mux (.sel(sign_q), .d0(acc[N-1:0]), .d1(neg_prod[N-1:0]), .y(lo_fix));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      rem      <= '0;
      opb      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        // divide-by-zero preloads the raw dividend and all-ones so FIX passes them through
        acc      <= {{N{1'b0}}, div0_in ? {N{1'b1}} : abs_a};
        rem      <= div0_in ? a : '0;
        opb      <= abs_b;
        cnt      <= CW'(N - 1);
        sign_q   <= signed_in && (a[N-1] ^ b[N-1]) && !div0_in;
        sign_r   <= signed_in && a[N-1] && !div0_in;
        div_q    <= div_in;
        div0_q   <= div0_in;
        div_zero <= 1'b0;
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        if (div_q) begin
          rem          <= borrow ? div_sh[N-1:0] : div_tr[N-1:0];
          acc[N-1:0]   <= {acc[N-2:0], ~borrow};
        end else begin
          acc <= {mul_sum, acc[N-1:1]};
        end
      end else if (state == FIX) begin
        hi       <= hi_fix;
        lo       <= lo_fix;
        div_zero <= div0_q;
      end
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven and scoreboarded checks of mul_div_unit.
module tb_mul_div_unit;
  logic        clk, rst_n, start, busy, done, div_zero;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  int tests = 0, failed = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t vecs[11];
  vec_t sb[$];
  mul_div_unit #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    logic [63:0] p;
    v.op = o; v.a = x; v.b = y; v.dz = 1'b0;
    if (o[1] && y == 0) begin
      v.hi = x; v.lo = '1; v.dz = 1'b1;
    end else if (o == 2'b00) begin
      p = {32'b0, x} * {32'b0, y}; v.hi = p[63:32]; v.lo = p[31:0];
    end else if (o == 2'b01) begin
      p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); v.hi = p[63:32]; v.lo = p[31:0];
    end else if (o == 2'b10) begin
      v.lo = x / y; v.hi = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      v.lo = 32'h8000_0000; v.hi = '0;
    end else begin
      v.lo = $signed(x) / $signed(y); v.hi = $signed(x) % $signed(y);
    end
    return v;
  endfunction
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
      end
    end
  end
  task automatic run_op(input vec_t v, input int poke);
    int lat;
    logic [31:0] hi0, lo0;
    bit stable, busy_ok;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    sb.push_back(v);
    hi0 = hi; lo0 = lo; stable = 1; busy_ok = 1;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 100) begin
      if (hi !== hi0 || lo !== lo0) stable = 0;
      if (busy !== 1'b1) busy_ok = 0;
      start = (lat == poke);
      a = $urandom; b = $urandom; op = 2'($urandom);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), (v.op[1] && v.b == 0) ? 32'd2 : 32'd34);
    chk("hold_mid_calc", 32'(stable), 32'd1);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd1);
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[5]  = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
    vecs[8]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{2'b00, 32'd0,         32'h1234_5678, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) run_op(vecs[i], 0);
    for (int i = 0; i < 16; i++) run_op(model(2'(i % 4), $urandom, (i % 8 == 7) ? 32'd0 : $urandom), 0);
    run_op(model(2'b01, 32'd12345, 32'hFFFF_FFFD), 10);
    @(negedge clk);
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    begin
      bit seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end
    rst_n = 1'b1;
    run_op(vecs[3], 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the CPU execute stage, implementing MIPS MULT, MULTU, DIV and DIVU into HI/LO. It takes operands from the register-read datapath and produces HI/LO. Those registers feed the writeback result-select mux via MFHI and MFLO. Each operation takes a fixed, multi-cycle latency. The pipeline controller stalls on `busy`.

## Interface
- `N`, 32: operand width; HI and LO are each N bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  N  multiplicand or dividend (rs).
- `b`  in  N  multiplier or divisor (rt).
- `busy`  out  1  high from the cycle after an accepted start until `done`, inclusive.
- `done`  out  1  one-cycle pulse when `hi` and `lo` become valid.
- `hi`  out  N  product[2N-1:N], or remainder.
- `lo`  out  N  product[N-1:0], or quotient.
- `div_zero`  out  1  set with `done` when a divide had b = 0; held until the next accepted start.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: iterates.
  - FIX: applies sign correction.
  - DONE: pulses `done`, then returns to IDLE.
- Accepted start (IDLE and `start`=1) latches `op`, then sets the working operands:
  - Unsigned ops: a and b as given.
  - Signed ops: the magnitudes |a| and |b|. The N-bit unsigned magnitude handles -2^(N-1).
  - Also latches sign_q = a[N-1]^b[N-1] and sign_r = a[N-1] for signed ops, both 0 for unsigned ops.
- Multiply: shift-add, one multiplier bit per cycle, into a 2N-bit accumulator.
- Divide: restoring division, one quotient bit per cycle.
  - Uses an (N+1)-bit partial remainder.
  - Each cycle, the quotient bit is set iff the trial subtraction does not borrow.
- Iteration count: a counter counts N CALC cycles, from N-1 down to 0; the transition CALC→FIX happens when the count is 0.
- FIX rules:
  - Multiply: negate the 2N-bit product (two's complement) if sign_q.
  - Divide: negate the quotient if sign_q; negate the remainder if sign_r.
  - The remainder sign follows the dividend.
- DIV by zero (b = 0 at accept, either divide op):
  - Path: IDLE→FIX→DONE; CALC is skipped.
  - Result: hi = a (raw), lo = all ones, div_zero = 1.
- DIV of -2^(N-1) by -1: lo = 0x8000_0000 (N=32), hi = 0, with no special case.
- `start` while not IDLE is ignored.
- `a`, `b` and `op` may change freely after the accept cycle.
- `hi`/`lo` change only on the FIX→DONE edge. They hold the last result until the next one completes, so they are never observed mid-calculation.

## Timing
- Accept at edge 0 → CALC for edges 1..N → FIX at edge N+1 → DONE (`done`=1) visible during cycle N+2.
- Start-to-done latency is therefore N+2 cycles, i.e. 34 for N=32.
- Divide by zero: `done` is visible 2 cycles after the accept.
- The earliest next accept is the cycle after DONE, when the state is back in IDLE.
- `busy` is 0 in IDLE, and 1 in CALC, FIX and DONE.
- Reset values: state = IDLE; `busy`, `done` and `div_zero` = 0; `hi` and `lo` = 0; counter = 0.
- Reset asserted mid-operation aborts immediately:
  - All outputs go to their reset values asynchronously.
  - No `done` pulse is produced for the aborted operation.

## Structure
- Shared CPU package holds:
  - The op encodings (MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV), reused by the control decoder.
  - The state encoding (2-bit: IDLE, CALC, FIX, DONE).
- Sign selection (value versus negated value) uses the codebase's generic N-bit 2:1 mux, instantiated per corrected field.
- Single module otherwise; no further sub-modules.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → `done` at cycle 34, hi=0xFFFF_FFFE, lo=0x0000_0001, div_zero=0.
- MULT a=-7 (0xFFFF_FFF9), b=6 → hi=0xFFFF_FFFF, lo=0xFFFF_FFD6 (-42).
- DIV a=-7, b=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU a=5, b=0 → `done` 2 cycles after accept; hi=5, lo=0xFFFF_FFFF, div_zero=1.
- Protocol and reset:
  - Pulse `start` with new operands at cycle 10 of a multiply → ignored; the first result is unchanged.
  - Assert rst_n=0 at cycle 20 of a divide → busy=0, hi=lo=0 immediately, no `done`.
  - A new start after reset release completes normally.
